// File: rtl/ls74_pkg.sv
// Shared constants and types for the 74LSxx-style shift register blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ls74_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] FRAME_LEN = 4'd8;

    // Frame sequencer states: IDLE between frames, SHIFT while a loaded word
    // is still being clocked out.
    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_SHIFT = 1'b1
    } seq_state_t;

endpackage : ls74_pkg

// File: rtl/shift_register_piso_8bit_core.sv
// Pure 74LS165 register function: synchronous load, enabled shift, hold.
// Latency: Q7 reflects a load or shift from the same rising CP edge.
// Backpressure: none; CE_n high stalls the register indefinitely.
//
// Ports:
//   cp           clock, rising edge
//   mr_n         synchronous active-low reset (register -> 0)
//   pl_n         synchronous active-low parallel load, beats shift
//   ce_n         active-low shift enable
//   ds           serial cascade input into stage 0
//   d            parallel data, d[7] leaves first
//   q7 / q7_n    stage 7 and its complement
module ls165_core
    import ls74_pkg::*;
(
    input  logic              cp,
    input  logic              mr_n,
    input  logic              pl_n,
    input  logic              ce_n,
    input  logic              ds,
    input  logic [WORD_W-1:0] d,
    output logic              q7,
    output logic              q7_n
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge cp) begin
        if (!mr_n) begin
            sr <= '0;
        end else if (!pl_n) begin
            sr <= d;
        end else if (!ce_n) begin
            sr <= {sr[WORD_W-2:0], ds};
        end
    end

    // Outputs come only from the register MSB so no input reaches them
    // combinationally.
    assign q7   = sr[WORD_W-1];
    assign q7_n = ~sr[WORD_W-1];

endmodule : ls165_core

// File: rtl/shift_register_piso_8bit.sv
// 8-bit PISO shift register with a frame sequencer (BUSY/BIT_CNT/DONE).
// Latency: Q7 valid from the load edge; DONE pulses the cycle after the 8th shift edge.
// Backpressure: CE_n high stalls data and count; a frame may stall indefinitely.
//
// Ports:
//   CP       clock, all state changes on rising edge
//   MR_n     synchronous active-low reset
//   PL_n     synchronous active-low parallel load (starts a frame)
//   CE_n     active-low shift enable
//   DS       serial cascade input
//   D        parallel word, D[7] first out
//   Q7/Q7_n  serial output and complement
//   BUSY     frame in progress
//   BIT_CNT  shifts completed in the current frame (0..8)
//   DONE     one-cycle pulse marking the downstream receiver word valid
module shift_register_piso_8bit
    import ls74_pkg::*;
(
    input  logic              CP,
    input  logic              MR_n,
    input  logic              PL_n,
    input  logic              CE_n,
    input  logic              DS,
    input  logic [WORD_W-1:0] D,
    output logic              Q7,
    output logic              Q7_n,
    output logic              BUSY,
    output logic [CNT_W-1:0]  BIT_CNT,
    output logic              DONE
);

    seq_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             done;

    ls165_core u_core (
        .cp   (CP),
        .mr_n (MR_n),
        .pl_n (PL_n),
        .ce_n (CE_n),
        .ds   (DS),
        .d    (D),
        .q7   (Q7),
        .q7_n (Q7_n)
    );

    // Sequencer mirrors the core's priority (reset > load > shift > hold).
    // Only shifts taken in SHIFT count; shifts in IDLE still move data in the
    // core (cascade use) but leave BIT_CNT and DONE alone.
    always_ff @(posedge CP) begin
        if (!MR_n) begin
            state   <= SEQ_IDLE;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            // DONE is a single-cycle pulse; every non-terminal edge clears it,
            // including a load landing in the same cycle DONE is high.
            done <= 1'b0;
            if (!PL_n) begin
                // A load always (re)starts a frame; an aborted frame gets no DONE.
                state   <= SEQ_SHIFT;
                bit_cnt <= '0;
            end else if (!CE_n && state == SEQ_SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == FRAME_LEN - 1'b1) begin
                    state <= SEQ_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign BUSY    = (state == SEQ_SHIFT);
    assign BIT_CNT = bit_cnt;
    assign DONE    = done;

endmodule : shift_register_piso_8bit

// File: doc/shift_register_piso_8bit.md
Name: shift_register_piso_8bit

Overview:
- 8-bit parallel-in/serial-out shift register with 74LS165-style function: parallel load, clock enable, serial cascade input, true/complement serial outputs.
- Adds a frame sequencer: counts shifts after each load and flags completion, so the block can drive the SIPO shift_register_8bit receiver directly as a word transmitter.
- Sits on the transmit side of the 74LSXX library. Its Q7 connects to the receiver's DSA, with DSB tied high and a common CP.

Parameters:
- None. Width is fixed at 8 to match the 74LS165 pinout. Constants are in the package.

Ports:
- CP      input   1  clock; all state changes on rising edge
- MR_n    input   1  reset, synchronous, active-low
- PL_n    input   1  parallel load, active-low, synchronous in this block
- CE_n    input   1  clock enable, active-low; shifting occurs only when low
- DS      input   1  serial data in, shifted into stage 0 (cascade input)
- D       input   8  parallel data; D[7] is the first bit out
- Q7      output  1  serial out = stage 7
- Q7_n    output  1  complement of Q7
- BUSY    output  1  frame in progress; high from a load until its 8th shift
- BIT_CNT output  4  shifts completed in the current frame, 0..8
- DONE    output  1  one-cycle pulse after the 8th shift of a frame

Behaviour:
- Priority at each rising CP edge: MR_n low > PL_n low > CE_n low > hold.
- Reset (MR_n=0 at an edge):
  - shift reg = 8'h00, so Q7=0 and Q7_n=1
  - BUSY=0, BIT_CNT=0, DONE=0
- Load (PL_n=0):
  - reg <= D, BUSY <= 1, BIT_CNT <= 0, DONE <= 0
  - CE_n and DS are ignored that cycle.
  - Q7 = D[7] is valid from this edge.
- Shift (PL_n=1, CE_n=0):
  - reg <= {reg[6:0], DS}
  - Q7 then presents the next lower original bit.
  - After k shifts, Q7 = original D[7-k] for k = 0..7.
- Counting:
  - Only shifts taken while BUSY=1 count.
  - BIT_CNT increments per counted shift.
  - On the 8th counted shift: BIT_CNT=8, BUSY<=0, DONE<=1 for exactly one cycle.
  - BIT_CNT holds 8 until the next load or reset.
- Shifts with BUSY=0 still move data, keeping the 74LS165 cascade function, but do not change BIT_CNT or DONE.
- CE_n high: reg, BIT_CNT and BUSY hold. A frame may stall indefinitely.
- Load while BUSY=1: the frame restarts from the new D with BIT_CNT=0 and no DONE pulse for the aborted frame.
- Load in the same cycle DONE is high: DONE still drops next cycle, and the new frame starts normally.
- Reset mid-frame: everything returns to reset values at that edge. No DONE pulse.
- Q7 and Q7_n are combinational from the register MSB only, with no other path from inputs.
- Timing contract with the SIPO receiver on a shared CP:
  - The receiver samples Q7 on each counted shift edge.
  - After the 8th shift edge, receiver Q7..Q0 = original D[7:0].
  - DONE asserting marks the receiver word valid.

Decomposition:
- Package ls74_pkg:
  - WORD_W = 8
  - CNT_W = 4
  - FRAME_LEN = 4'd8
- The register core (load/shift/hold) is natural as sub-module ls165_core, the pure 74LS165 function without counting.
- The top wraps ls165_core with the BUSY/BIT_CNT/DONE sequencer: a two-state FSM, IDLE and SHIFT, where DONE is a registered pulse on the SHIFT -> IDLE transition.

Test Plan:
- Reset: MR_n=0 for 2 edges with D=8'hFF and PL_n=0 -> Q7=0, Q7_n=1, BUSY=0, BIT_CNT=0, DONE=0. Reset overrides load.
- Load then shift: load D=8'hA5, then 8 edges with CE_n=0 and DS=0 -> Q7 sequence 1,0,1,0,0,1,0,1. BIT_CNT steps 1..8. DONE high exactly one cycle after the 8th shift. BUSY falls with it.
- Loopback: Q7 drives the shift_register_8bit receiver's DSA (DSB=1), with common CP and MR_n. Load 8'h3C and shift 8 -> receiver Q7..Q0 = 0,0,1,1,1,1,0,0 when DONE=1.
- Stall and abort:
  - Load 8'hF0 and shift 3, hold CE_n=1 for 5 cycles -> Q7 and BIT_CNT=3 hold.
  - Then load 8'h0F -> BIT_CNT=0, no DONE. Eight more shifts -> DONE once.
- Cascade and priority:
  - With BUSY=0 and DS=1, shift 8 times from 8'h00 -> reg=8'hFF; BIT_CNT stays 8 and DONE stays 0.
  - PL_n=0 with CE_n=0 in the same cycle -> load wins.
- Reset mid-frame: load 8'h81, shift 4, MR_n=0 for one edge -> all outputs at reset values and no DONE.
